// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared op encoding and pipeline result record for the branch unit
package branch_pkg;

    localparam int BR_PC_WIDTH       = 8;
    localparam int BR_DATA_WIDTH     = 128;
    localparam int BR_REG_ADDR_WIDTH = 7;

    typedef enum logic [3:0] {
        NOP,
        BR,
        BRA,
        BRSL,
        BRASL,
        BI,
        BISL,
        BIZ,
        BINZ,
        BIHZ,
        BIHNZ,
        BRZ,
        BRNZ,
        BRHZ,
        BRHNZ
    } br_op_t;

    typedef struct packed {
        logic                         valid;
        logic                         taken;
        logic [BR_PC_WIDTH-1:0]       target;
        logic [0:BR_DATA_WIDTH-1]     link_data;
        logic [BR_REG_ADDR_WIDTH-1:0] reg_addr;
        logic                         wr_en;
    } br_result_t;

    function automatic logic is_link(br_op_t op);
        return (op == BRSL) || (op == BRASL) || (op == BISL);
    endfunction

endpackage

// File: rtl/branch_unit_pipe_if.sv
// rtl/branch_unit_pipe_if.sv - issue and writeback bundle of the pipelined branch unit
interface branch_unit_pipe_if import branch_pkg::*; #(
   parameter int PC_WIDTH       = 8,
   parameter int DATA_WIDTH     = 128,
   parameter int REG_ADDR_WIDTH = 7,
   parameter int IMM_WIDTH      = 16
) ();
   logic                      in_valid;
   br_op_t                    op;
   logic                      initial_;
   logic [REG_ADDR_WIDTH-1:0] dest_reg_addr;
   logic [0:DATA_WIDTH-1]     src_reg_a;
   logic [0:DATA_WIDTH-1]     store_reg;
   logic [IMM_WIDTH-1:0]      imm_value;
   logic                      enable_reg_write;
   logic [PC_WIDTH-1:0]       program_counter_input;
   logic                      flush_in;

   logic                      wb_valid;
   logic [0:DATA_WIDTH-1]     wb_data;
   logic [REG_ADDR_WIDTH-1:0] wb_reg_addr;
   logic                      wb_enable_reg_write;
   logic [PC_WIDTH-1:0]       program_counter_wb;
   logic                      branch_is_taken;
   logic                      disable_branch;
   logic                      squash_active;

   modport master (
      output in_valid, op, initial_, dest_reg_addr, src_reg_a, store_reg,
             imm_value, enable_reg_write, program_counter_input, flush_in,
      input  wb_valid, wb_data, wb_reg_addr, wb_enable_reg_write,
             program_counter_wb, branch_is_taken, disable_branch, squash_active
   );

   modport slave (
      input  in_valid, op, initial_, dest_reg_addr, src_reg_a, store_reg,
             imm_value, enable_reg_write, program_counter_input, flush_in,
      output wb_valid, wb_data, wb_reg_addr, wb_enable_reg_write,
             program_counter_wb, branch_is_taken, disable_branch, squash_active
   );
endinterface

// File: rtl/branch_stage_pipe.sv
// rtl/branch_stage_pipe.sv - DEPTH-deep register chain carrying resolved branch results
module branch_stage_pipe import branch_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   input  br_result_t d,
   output br_result_t q
);
   br_result_t stage [DEPTH];

   // Flush wipes whole entries so an invalid slot never leaks stale data to writeback.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];
endmodule

// File: rtl/branch_unit_pipe.sv
// rtl/branch_unit_pipe.sv - resolves branch target/condition at issue and delivers it LATENCY cycles later
module branch_unit_pipe import branch_pkg::*; #(
   parameter int PC_WIDTH       = 8,
   parameter int DATA_WIDTH     = 128,
   parameter int REG_ADDR_WIDTH = 7,
   parameter int IMM_WIDTH      = 16,
   parameter int LATENCY        = 2,
   parameter int SHADOW         = 2
) (
   input logic               clock,
   input logic               reset,
   branch_unit_pipe_if.slave bus
);
   localparam int CNT_WIDTH = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

   logic [PC_WIDTH-1:0]           own;
   logic [PC_WIDTH-1:0]           own_next;
   logic [PC_WIDTH-1:0]           imm_pc;
   logic [PC_WIDTH-1:0]           rel_target;
   logic [PC_WIDTH-1:0]           ind_target;
   logic [PC_WIDTH+IMM_WIDTH-1:0] imm_sext;
   logic [31:0]                   word_a;
   logic [31:0]                   word_c;
   logic [15:0]                   half_c;
   logic                          word_zero;
   logic                          half_zero;
   logic                          taken;
   logic [PC_WIDTH-1:0]           target;
   logic                          accepted;
   logic [CNT_WIDTH-1:0]          squash_cnt;
   br_result_t                    res;
   br_result_t                    stage_in;
   br_result_t                    stage_out;
   logic                          unused_bits;

   // Big-endian numbering: word 0 is the most significant 32 bits of the register.
   assign word_a    = bus.src_reg_a[0:31];
   assign word_c    = bus.store_reg[0:31];
   assign half_c    = bus.store_reg[16:31];
   assign word_zero = (word_c == 32'd0);
   assign half_zero = (half_c == 16'd0);

   assign imm_sext   = {{PC_WIDTH{bus.imm_value[IMM_WIDTH-1]}}, bus.imm_value};
   assign imm_pc     = imm_sext[PC_WIDTH-1:0];
   assign own        = bus.program_counter_input - (bus.initial_ ? PC_WIDTH'(2) : PC_WIDTH'(1));
   assign own_next   = own + PC_WIDTH'(1);
   assign rel_target = own + imm_pc;
   assign ind_target = word_a[PC_WIDTH-1:0];

   always_comb begin
      taken  = 1'b0;
      target = rel_target;
      case (bus.op)
         BR, BRSL:   taken = 1'b1;
         BRA, BRASL: begin taken = 1'b1;       target = imm_pc;     end
         BI, BISL:   begin taken = 1'b1;       target = ind_target; end
         BIZ:        begin taken = word_zero;  target = ind_target; end
         BINZ:       begin taken = !word_zero; target = ind_target; end
         BIHZ:       begin taken = half_zero;  target = ind_target; end
         BIHNZ:      begin taken = !half_zero; target = ind_target; end
         BRZ:        taken = word_zero;
         BRNZ:       taken = !word_zero;
         BRHZ:       taken = half_zero;
         BRHNZ:      taken = !half_zero;
         default:    taken = 1'b0;
      endcase
   end

   always_comb begin
      res        = '0;
      res.valid  = 1'b1;
      res.taken  = taken;
      res.target = taken ? target : '0;
      if (is_link(bus.op)) begin
         res.link_data[0:31] = {{(32-PC_WIDTH){1'b0}}, own_next};
         res.reg_addr        = bus.dest_reg_addr;
         res.wr_en           = bus.enable_reg_write;
      end
   end

   assign accepted           = bus.in_valid && !bus.flush_in && (squash_cnt == '0);
   assign stage_in           = accepted ? res : '0;
   assign bus.disable_branch = accepted && taken && bus.initial_;

   // Only an accepted taken branch opens the window; drops inside it never reload.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         squash_cnt <= '0;
      end else if (bus.flush_in) begin
         squash_cnt <= '0;
      end else if (accepted && taken) begin
         squash_cnt <= CNT_WIDTH'(SHADOW);
      end else if (squash_cnt != '0) begin
         squash_cnt <= squash_cnt - CNT_WIDTH'(1);
      end
   end

   branch_stage_pipe #(.DEPTH(LATENCY)) u_stage_pipe (
      .clock (clock),
      .reset (reset),
      .flush (bus.flush_in),
      .d     (stage_in),
      .q     (stage_out)
   );

   assign bus.wb_valid            = stage_out.valid;
   assign bus.branch_is_taken     = stage_out.taken;
   assign bus.program_counter_wb  = stage_out.target;
   assign bus.wb_data             = stage_out.link_data;
   assign bus.wb_reg_addr         = stage_out.reg_addr;
   assign bus.wb_enable_reg_write = stage_out.wr_en;
   assign bus.squash_active       = (squash_cnt != '0);

   assign unused_bits = ^{bus.src_reg_a[32:DATA_WIDTH-1], word_a[31:PC_WIDTH],
                          imm_sext[PC_WIDTH+IMM_WIDTH-1:PC_WIDTH]};
endmodule

// File: tb/tb_branch_unit_pipe.sv
// tb/tb_branch_unit_pipe.sv - self-checking bench for branch_unit_pipe
module tb_branch_unit_pipe;
   import branch_pkg::*;

   localparam int LAT = 2;
   localparam int SH  = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   branch_unit_pipe_if bus ();

   branch_unit_pipe dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic         v;
      logic         taken;
      logic [7:0]   tgt;
      logic [127:0] data;
      logic [6:0]   addr;
      logic         we;
   } exp_t;

   function automatic exp_t model(br_op_t op, bit init, logic [7:0] pc, logic [15:0] imm,
                                  logic [127:0] src, logic [127:0] store, bit en, logic [6:0] dest);
      exp_t        e;
      int          own, rel, ind, tgt;
      logic [31:0] wa, wc, hc;
      bit          tk;
      e   = '0;
      e.v = 1'b1;
      own = (int'(pc) - (init ? 2 : 1)) & 255;
      rel = (own + int'($signed(imm))) & 255;
      wa  = 32'(src >> 96);
      wc  = 32'(store >> 96);
      hc  = wc & 32'hFFFF;
      ind = int'(wa % 256);
      tk  = 1'b0;
      tgt = rel;
      case (op)
         BR, BRSL:   tk = 1'b1;
         BRA, BRASL: begin tk = 1'b1; tgt = int'(imm) & 255; end
         BI, BISL:   begin tk = 1'b1; tgt = ind; end
         BIZ:        begin tk = (wc == 0); tgt = ind; end
         BINZ:       begin tk = (wc != 0); tgt = ind; end
         BIHZ:       begin tk = (hc == 0); tgt = ind; end
         BIHNZ:      begin tk = (hc != 0); tgt = ind; end
         BRZ:        tk = (wc == 0);
         BRNZ:       tk = (wc != 0);
         BRHZ:       tk = (hc == 0);
         BRHNZ:      tk = (hc != 0);
         default:    tk = 1'b0;
      endcase
      e.taken = tk;
      e.tgt   = tk ? 8'(tgt) : 8'd0;
      if (op inside {BRSL, BRASL, BISL}) begin
         e.data = 128'((own + 1) % 256) << 96;
         e.addr = dest;
         e.we   = en;
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.in_valid              = 1'b0;
      bus.op                    = NOP;
      bus.initial_              = 1'b0;
      bus.dest_reg_addr         = '0;
      bus.src_reg_a             = '0;
      bus.store_reg             = '0;
      bus.imm_value             = '0;
      bus.enable_reg_write      = 1'b0;
      bus.program_counter_input = '0;
      bus.flush_in              = 1'b0;
   endtask

   task automatic issue(br_op_t op, bit init, logic [7:0] pc, logic [15:0] imm,
                        logic [127:0] src, logic [127:0] store, bit en, logic [6:0] dest, bit fl);
      bus.in_valid              = 1'b1;
      bus.op                    = op;
      bus.initial_              = init;
      bus.program_counter_input = pc;
      bus.imm_value             = imm;
      bus.src_reg_a             = src;
      bus.store_reg             = store;
      bus.enable_reg_write      = en;
      bus.dest_reg_addr         = dest;
      bus.flush_in              = fl;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid: got %0b want 0", bus.wb_valid); end
      n_cmp++; if (bus.branch_is_taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %0b want 0", bus.branch_is_taken); end
      n_cmp++; if (bus.program_counter_wb !== 8'd0) begin n_bad++; $display("FAIL reset_pc_wb: got %0h want 0", bus.program_counter_wb); end
      n_cmp++; if (bus.wb_data !== 128'd0) begin n_bad++; $display("FAIL reset_wb_data: got %0h want 0", bus.wb_data); end
      n_cmp++; if (bus.squash_active !== 1'b0) begin n_bad++; $display("FAIL reset_squash: got %0b want 0", bus.squash_active); end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_br();
      issue(BR, 1'b1, 8'd10, 16'd5, '0, '0, 1'b0, 7'd0, 1'b0);
      @(negedge clock);
      n_cmp++; if (bus.disable_branch !== 1'b1) begin n_bad++; $display("FAIL br_disable: got %0b want 1", bus.disable_branch); end
      step(); idle();
      @(negedge clock);
      n_cmp++; if (bus.squash_active !== 1'b1) begin n_bad++; $display("FAIL br_squash_n1: got %0b want 1", bus.squash_active); end
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL br_early_valid: got %0b want 0", bus.wb_valid); end
      step();
      @(negedge clock);
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL br_wb_valid: got %0b want 1", bus.wb_valid); end
      n_cmp++; if (bus.program_counter_wb !== 8'd13) begin n_bad++; $display("FAIL br_target: got %0d want 13", bus.program_counter_wb); end
      n_cmp++; if (bus.branch_is_taken !== 1'b1) begin n_bad++; $display("FAIL br_taken: got %0b want 1", bus.branch_is_taken); end
      n_cmp++; if (bus.squash_active !== 1'b1) begin n_bad++; $display("FAIL br_squash_n2: got %0b want 1", bus.squash_active); end
      step();
      @(negedge clock);
      n_cmp++; if (bus.squash_active !== 1'b0) begin n_bad++; $display("FAIL br_squash_n3: got %0b want 0", bus.squash_active); end
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL br_one_cycle: got %0b want 0", bus.wb_valid); end
      step();
   endtask

   task automatic test_brsl();
      issue(BRSL, 1'b0, 8'd20, 16'hFFFD, '0, '0, 1'b1, 7'd7, 1'b0);
      step(); idle(); step();
      @(negedge clock);
      n_cmp++; if (bus.program_counter_wb !== 8'd16) begin n_bad++; $display("FAIL brsl_target: got %0d want 16", bus.program_counter_wb); end
      n_cmp++; if (bus.wb_data !== (128'd20 << 96)) begin n_bad++; $display("FAIL brsl_data: got %0h want %0h", bus.wb_data, 128'd20 << 96); end
      n_cmp++; if (bus.wb_reg_addr !== 7'd7) begin n_bad++; $display("FAIL brsl_addr: got %0d want 7", bus.wb_reg_addr); end
      n_cmp++; if (bus.wb_enable_reg_write !== 1'b1) begin n_bad++; $display("FAIL brsl_we: got %0b want 1", bus.wb_enable_reg_write); end
      repeat (2) step();
   endtask

   task automatic test_back_to_back_cond();
      issue(BRHNZ, 1'b0, 8'd50, 16'd4, '0, 128'hFFFF0000 << 96, 1'b0, 7'd0, 1'b0);
      step();
      issue(BRHNZ, 1'b0, 8'd50, 16'd4, '0, 128'h00000001 << 96, 1'b0, 7'd0, 1'b0);
      step(); idle();
      @(negedge clock);
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL cond_nt_valid: got %0b want 1", bus.wb_valid); end
      n_cmp++; if (bus.branch_is_taken !== 1'b0) begin n_bad++; $display("FAIL cond_nt_taken: got %0b want 0", bus.branch_is_taken); end
      n_cmp++; if (bus.program_counter_wb !== 8'd0) begin n_bad++; $display("FAIL cond_nt_pc: got %0d want 0", bus.program_counter_wb); end
      step();
      @(negedge clock);
      n_cmp++; if (bus.branch_is_taken !== 1'b1) begin n_bad++; $display("FAIL cond_t_taken: got %0b want 1", bus.branch_is_taken); end
      n_cmp++; if (bus.program_counter_wb !== 8'd53) begin n_bad++; $display("FAIL cond_t_pc: got %0d want 53", bus.program_counter_wb); end
      repeat (3) step();
   endtask

   task automatic test_squash();
      issue(BRA, 1'b1, 8'd30, 16'h0040, '0, '0, 1'b0, 7'd0, 1'b0);
      step();
      issue(BI, 1'b0, 8'd31, 16'd0, 128'h55 << 96, '0, 1'b0, 7'd0, 1'b0);
      @(negedge clock);
      n_cmp++; if (bus.disable_branch !== 1'b0) begin n_bad++; $display("FAIL sq_disable_drop: got %0b want 0", bus.disable_branch); end
      step();
      @(negedge clock);
      n_cmp++; if (bus.program_counter_wb !== 8'h40) begin n_bad++; $display("FAIL sq_bra_pc: got %0h want 40", bus.program_counter_wb); end
      step();
      issue(BI, 1'b0, 8'd33, 16'd0, 128'h1F3 << 96, '0, 1'b0, 7'd0, 1'b0);
      @(negedge clock);
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL sq_drop1: got %0b want 0", bus.wb_valid); end
      n_cmp++; if (bus.squash_active !== 1'b0) begin n_bad++; $display("FAIL sq_window_end: got %0b want 0", bus.squash_active); end
      step(); idle();
      @(negedge clock);
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL sq_drop2: got %0b want 0", bus.wb_valid); end
      step();
      @(negedge clock);
      n_cmp++; if (bus.program_counter_wb !== 8'hF3) begin n_bad++; $display("FAIL sq_bi_pc: got %0h want f3", bus.program_counter_wb); end
      n_cmp++; if (bus.branch_is_taken !== 1'b1) begin n_bad++; $display("FAIL sq_bi_taken: got %0b want 1", bus.branch_is_taken); end
      repeat (3) step();
   endtask

   task automatic test_wrap();
      issue(BR, 1'b1, 8'd1, 16'hFFFE, '0, '0, 1'b0, 7'd0, 1'b0);
      step(); idle(); step();
      @(negedge clock);
      n_cmp++; if (bus.program_counter_wb !== 8'd253) begin n_bad++; $display("FAIL wrap_pc: got %0d want 253", bus.program_counter_wb); end
      repeat (2) step();
   endtask

   task automatic test_flush();
      issue(BRZ, 1'b1, 8'd60, 16'd2, '0, 128'h1 << 96, 1'b0, 7'd0, 1'b0);
      step();
      issue(BR, 1'b1, 8'd70, 16'd3, '0, '0, 1'b0, 7'd0, 1'b1);
      @(negedge clock);
      n_cmp++; if (bus.disable_branch !== 1'b0) begin n_bad++; $display("FAIL flush_disable: got %0b want 0", bus.disable_branch); end
      step(); idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wb_valid_%0d: got %0b want 0", i, bus.wb_valid); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      issue(BRSL, 1'b0, 8'd90, 16'd1, '0, '0, 1'b1, 7'd3, 1'b0);
      step(); idle(); step();
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %0b want 1", bus.wb_valid); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %0b want 0", bus.wb_valid); end
      n_cmp++; if (bus.wb_data !== 128'd0) begin n_bad++; $display("FAIL rst_async_data: got %0h want 0", bus.wb_data); end
      n_cmp++; if (bus.squash_active !== 1'b0) begin n_bad++; $display("FAIL rst_async_squash: got %0b want 0", bus.squash_active); end
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_cmp++; if (bus.branch_is_taken !== 1'b0) begin n_bad++; $display("FAIL rst_no_redirect_%0d: got %0b want 0", i, bus.branch_is_taken); end
         step();
      end
   endtask

   task automatic test_random();
      exp_t         pend [int];
      exp_t         e, want;
      int           sq_until;
      int           dels [$];
      bit           v, fl, init, en, acc;
      br_op_t       op;
      logic [7:0]   pc;
      logic [15:0]  imm;
      logic [127:0] src, store;
      logic [6:0]   dest;
      reset = 1'b1;
      idle();
      step();
      reset = 1'b0;
      sq_until = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         v     = ($urandom_range(0, 3) != 0);
         fl    = ($urandom_range(0, 19) == 0);
         op    = br_op_t'($urandom_range(0, 14));
         init  = 1'($urandom_range(0, 1));
         pc    = 8'($urandom);
         imm   = 16'($urandom);
         en    = 1'($urandom_range(0, 1));
         dest  = 7'($urandom);
         src   = {$urandom, $urandom, $urandom, $urandom};
         store = ($urandom_range(0, 2) == 0) ? 128'd0 :
                 ($urandom_range(0, 1) == 0) ? (128'($urandom & 32'hFFFF0000) << 96) :
                                               {$urandom, $urandom, $urandom, $urandom};
         if (v) issue(op, init, pc, imm, src, store, en, dest, fl);
         else begin idle(); bus.flush_in = fl; end
         @(negedge clock);
         acc  = v && !fl && (cyc >= sq_until);
         e    = model(op, init, pc, imm, src, store, en, dest);
         want = pend.exists(cyc) ? pend[cyc] : '0;
         n_cmp++; if (bus.disable_branch !== (acc && e.taken && init)) begin n_bad++; $display("FAIL rnd_disable c%0d: got %0b want %0b", cyc, bus.disable_branch, acc && e.taken && init); end
         n_cmp++; if (bus.squash_active !== (cyc < sq_until)) begin n_bad++; $display("FAIL rnd_squash c%0d: got %0b want %0b", cyc, bus.squash_active, cyc < sq_until); end
         n_cmp++; if (bus.wb_valid !== want.v) begin n_bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", cyc, bus.wb_valid, want.v); end
         n_cmp++; if (bus.branch_is_taken !== want.taken) begin n_bad++; $display("FAIL rnd_taken c%0d: got %0b want %0b", cyc, bus.branch_is_taken, want.taken); end
         n_cmp++; if (bus.program_counter_wb !== want.tgt) begin n_bad++; $display("FAIL rnd_pc c%0d: got %0h want %0h", cyc, bus.program_counter_wb, want.tgt); end
         n_cmp++; if (bus.wb_data !== want.data) begin n_bad++; $display("FAIL rnd_data c%0d: got %0h want %0h", cyc, bus.wb_data, want.data); end
         n_cmp++; if ({bus.wb_reg_addr, bus.wb_enable_reg_write} !== {want.addr, want.we}) begin n_bad++; $display("FAIL rnd_link c%0d: got %0h/%0b want %0h/%0b", cyc, bus.wb_reg_addr, bus.wb_enable_reg_write, want.addr, want.we); end
         pend.delete(cyc);
         if (fl) begin
            dels.delete();
            foreach (pend[k]) if (k > cyc) dels.push_back(k);
            foreach (dels[i]) pend.delete(dels[i]);
            sq_until = cyc + 1;
         end else if (acc) begin
            pend[cyc + LAT] = e;
            if (e.taken) sq_until = cyc + 1 + SH;
         end
         step();
      end
      idle();
      repeat (LAT + 1) step();
   endtask

   initial begin
      idle();
      test_reset();
      test_br();
      test_brsl();
      test_back_to_back_cond();
      test_squash();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_unit_pipe.md
Name: branch_unit_pipe

Overview:
Parametrised successor of the single-stage branch unit. It takes pre-decoded branch ops from the odd-pipe issue, resolves the target and the condition in stage 0, and carries the result through a LATENCY-deep pipe to writeback. It adds an issue-valid/writeback-valid handshake, a squash window that drops younger issues after a taken branch, an external flush, and a uniform PC-relative base for all relative branches.

Parameters:
PC_WIDTH, 8, width of the instruction-index PC; arithmetic is modulo 2^PC_WIDTH.
DATA_WIDTH, 128, register width; must be at least 32.
REG_ADDR_WIDTH, 7, register address width.
IMM_WIDTH, 16, width of the signed branch immediate.
LATENCY, 2, cycles from issue to writeback; must be at least 1.
SHADOW, 2, number of issue cycles squashed after a taken branch.

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high
in_valid  in  1  an op is issued this cycle
op  in  br_op_t  decoded branch op
initial_  in  1  op is the first of the issue pair
dest_reg_addr  in  REG_ADDR_WIDTH  link register address
src_reg_a  in  DATA_WIDTH  indirect target source; word 0 = bits [0:31]
store_reg  in  DATA_WIDTH  condition source
imm_value  in  IMM_WIDTH  signed offset, or absolute target
enable_reg_write  in  1  decoder write request
program_counter_input  in  PC_WIDTH  fetch PC at issue
flush_in  in  1  external pipeline flush
wb_valid  out  1  writeback slot valid
wb_data  out  DATA_WIDTH  link value
wb_reg_addr  out  REG_ADDR_WIDTH  link destination
wb_enable_reg_write  out  1  link write enable
program_counter_wb  out  PC_WIDTH  redirect target
branch_is_taken  out  1  redirect strobe
disable_branch  out  1  combinational; kill the twin in the current pair
squash_active  out  1  squash counter nonzero

Behaviour:
- Reset is asynchronous and active-high. It clears all stage valids, the squash counter and every registered output to 0.
- Own address of the branch: own = program_counter_input - (initial_ ? 2 : 1).
- Link value: link = own + 1, zero-extended into word 0. All other bits of the link data are 0.
- Halfword condition field: store_reg[16:31]. Word condition field: store_reg[0:31].
- Target and condition per op:
  - BR: own + sext(imm), always taken.
  - BRA: imm truncated to PC_WIDTH, always taken.
  - BRSL: as BR, plus link write.
  - BRASL: as BRA, plus link write.
  - BI: src_reg_a[0:31] truncated, always taken.
  - BISL: as BI, plus link write.
  - BIZ / BINZ: target as BI; taken if word field ==0 / !=0.
  - BIHZ / BIHNZ: target as BI; taken if halfword field ==0 / !=0.
  - BRZ / BRNZ: own + sext(imm); taken if word field ==0 / !=0.
  - BRHZ / BRHNZ: own + sext(imm); taken if halfword field ==0 / !=0.
  - NOP: wb_valid=1, all other outputs 0.
- Link write: wb_enable_reg_write = enable_reg_write AND op is a link op (BRSL, BRASL, BISL). It is forced 0 for every other op.
- Accepted issue: in_valid=1, flush_in=0 and squash counter==0.
  - An accepted issue at cycle N appears with wb_valid=1 at cycle N+LATENCY.
  - Outputs are registered and valid for exactly one cycle.
  - When wb_valid=0, all data outputs are 0.
- Not-taken conditional: wb_valid=1, branch_is_taken=0, program_counter_wb=0.
- disable_branch = accepted issue AND resolved taken AND initial_. It is combinational in the issue cycle.
- Squash counter:
  - An accepted taken branch loads the counter with SHADOW.
  - While the counter is nonzero, every in_valid issue is dropped silently and the counter decrements once per cycle.
  - A taken branch that arrives inside the window is dropped and does not reload the counter.
- flush_in in the same cycle as in_valid: flush wins. In-flight stage valids clear, the counter clears, and the issue that cycle is dropped. Results already on the outputs that cycle stay visible.
- Wrap-around: all PC arithmetic wraps modulo 2^PC_WIDTH. No saturation and no error flag.
- Reset mid-operation: all in-flight results are discarded and no redirect is emitted.

Decomposition:
- Package branch_pkg holds:
  - br_op_t enum (NOP, BR, BRA, BRSL, BRASL, BI, BISL, BIZ, BINZ, BIHZ, BIHNZ, BRZ, BRNZ, BRHZ, BRHNZ).
  - br_result_t struct (valid, taken, target, link data, reg addr, write enable).
  - Function is_link(op).
- Sub-module branch_stage_pipe: a parametrised LATENCY-deep register chain of br_result_t, with asynchronous reset and a synchronous flush that clears the valids.

Test Plan:
- BR, pc=10, initial_=1, imm=+5, LATENCY=2 -> wb_valid at N+2, program_counter_wb=13, branch_is_taken=1; disable_branch=1 at N; squash_active=1 for 2 cycles.
- BRSL, pc=20, initial_=0, imm=-3, enable_reg_write=1, dest=7 -> target=16, wb_data word0=20, wb_reg_addr=7, wb_enable_reg_write=1.
- BRHNZ, store_reg[16:31]=0 with store_reg[0:15]=FFFF -> not taken, wb_valid=1, program_counter_wb=0; repeat with [16:31]=0001 -> taken.
- BRA taken, then BI issued on each of the next 2 cycles -> both dropped; a BI on the 3rd cycle, src_reg_a word0=0x1F3 -> target 0xF3, taken.
- BR wrap-around: pc=1, initial_=1, imm=-2 -> own=255, target=253.
- flush_in asserted with in_valid while one op is in flight -> no wb_valid for either op; reset pulse mid-pipe -> all outputs 0 asynchronously.
